rd_burst_fsm: RTL
=================

# rd_burst_fsm

Parametrised burst read controller; next generation of the single-beat read/wait-state/done sequencer. After a `go` request it issues `len+1` read beats. Each beat holds `rd` through a READ/DLY pair and retries while the slave signals a wait state. A per-beat wait-state limit raises an error, and a synchronous abort is provided. It sits between a command source (go/len) and a slave with a `ws` wait-state handshake. All outputs are registered (glitch-free).

## Interface
- `CNT_W`, default 4: width of `len` and `beat`; max burst = 2^CNT_W beats.
- `MAX_WS`, default 7: consecutive wait states tolerated per beat, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous active-low.
- `go`  in  1  start request, sampled only in IDLE.
- `len`  in  CNT_W  beats minus one, captured with accepted `go`.
- `ws`  in  1  slave wait state, sampled only in DLY.
- `abort`  in  1  synchronous abort of a running burst.
- `rd`  out  1  read strobe, high in READ and DLY.
- `ds`  out  1  done, one-cycle pulse in DONE.
- `err`  out  1  timeout, one-cycle pulse in ERR.
- `busy`  out  1  high in every state except IDLE.
- `beat`  out  CNT_W  index of current beat, 0-based.

## Operation
- States: IDLE, READ, DLY, DONE, ERR.
- Internal counters:
  - `rem` (CNT_W), beats remaining after the current one.
  - `ws_cnt` (`$clog2(MAX_WS+1)` bits), wait states seen on the current beat.
- IDLE:
  - `go && !abort` → READ; load `rem=len`, `beat=0`, `ws_cnt=0`.
  - Otherwise stay in IDLE.
- READ → DLY unconditionally.
- DLY with `ws=1`:
  - `ws_cnt==MAX_WS` → ERR.
  - Otherwise `ws_cnt++` → READ; `beat` and `rem` unchanged (retry).
- DLY with `ws=0`:
  - `rem==0` → DONE.
  - Otherwise `rem--`, `beat++`, `ws_cnt=0` → READ.
- DONE → IDLE. ERR → IDLE.
- `abort=1` in any non-IDLE state → IDLE next cycle.
  - Overrides all other transitions.
  - No `ds`/`err` pulse is produced.
  - Counters are not cleared; they are reloaded on the next `go`.
- `abort` in IDLE blocks `go` that cycle. `go` while busy is ignored.
- Output registers are loaded from the next-state decode, so outputs change on the same edge as `state`:
  - `rd`=(READ|DLY).
  - `ds`=DONE.
  - `err`=ERR.
  - `busy`=!IDLE.
- `beat` is a register output.
- No counter wraps:
  - `rem` decrements only when nonzero.
  - `beat` ≤ `len` ≤ 2^CNT_W−1.
  - `ws_cnt` ≤ MAX_WS.
- Unreachable state encoding → IDLE next cycle; outputs take their IDLE values.

## Timing
- Reset values:
  - state IDLE.
  - `rd`=`ds`=`err`=`busy`=0, `beat`=0.
  - `rem`=`ws_cnt`=0.
- Asserting `rst_n` low mid-burst forces all of the above immediately. It does not wait for `clk`.
- `go` sampled at edge 0 → `rd`/`busy` high from edge 1.
- One beat, no wait states:
  - READ from edge 1, DLY from edge 2.
  - DONE from edge 3 (`ds`=1, `rd`=0).
  - IDLE from edge 4, where a new `go` may be sampled.
- N beats, no wait states: `rd` high for 2N cycles; `ds` high for 1 cycle immediately after.
- Each wait state adds 2 cycles (READ+DLY).
- Timeout: the (MAX_WS+1)th consecutive `ws=1` sample in DLY of one beat → ERR next cycle. `rd` drops the same edge.
- `beat` increments on the edge that enters the next beat's READ.
- Minimum go-to-go spacing: 4 cycles.

## Structure
- Shared package `rd_burst_pkg`:
  - `state_e` enum (IDLE, READ, DLY, DONE, ERR, plus an explicit X value for default assignment).
  - `WS_W(max_ws)` helper function.
- Single module with three processes: state register with outputs, next-state/next-output comb, counter registers.
- No sub-module required.

## Test plan
- Reset mid-DLY with `len=3`, `beat=2` → `rd`/`busy`/`beat` go to 0 asynchronously; IDLE after release.
- `len=0`, `ws=0` → `rd` high for edges 1–2, `ds` pulse at edge 3, `busy` low at edge 4.
- `len=3`, `ws` high once on beat 1 → `beat` sequence 0,0,1,1,1,1,2,2,3,3; `rd` high 10 cycles; single `ds`.
- MAX_WS=7, `ws` held high → 8 READ/DLY pairs, then `err` pulse. `ds` never asserts. `beat` stays 0.
- `abort` during beat 2 of `len=5` → IDLE next cycle, no `ds`/`err`. Next `go` with `len=1` restarts at `beat=0`.
- `go` held high throughout → back-to-back bursts every 2(len+1)+2 cycles. `go` with `abort` in IDLE → no start.

Source files
------------

// File: rtl/rd_burst_pkg.sv
// Shared types and sizing helpers for the burst read controller.
package rd_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_DLY  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4,
    ST_X    = 3'd7
  } state_e;

  // Bits needed to count 0..max_ws wait states.
  function automatic int unsigned WS_W(input int unsigned max_ws);
    return $clog2(max_ws + 1);
  endfunction

endpackage

// File: rtl/rd_burst_fsm.sv
// Burst read controller: len+1 READ/DLY beats with wait-state retry,
// per-beat wait-state timeout and synchronous abort. All outputs registered.
module rd_burst_fsm
  import rd_burst_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned MAX_WS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [CNT_W-1:0] len,
  input  logic             ws,
  input  logic             abort,
  output logic             rd,
  output logic             ds,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] beat
);

  localparam int unsigned WSW = WS_W(MAX_WS);

  state_e           state_q, state_d;
  logic             rd_d, ds_d, err_d, busy_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [WSW-1:0]   ws_cnt_q, ws_cnt_d;

  assign beat = beat_q;

  // State register; outputs load from the next-state decode so they move with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd      <= 1'b0;
      ds      <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd      <= rd_d;
      ds      <= ds_d;
      err     <= err_d;
      busy    <= busy_d;
    end
  end

  // Next-state, counter-update and next-output decode.
  always_comb begin
    state_d  = ST_X;
    rem_d    = rem_q;
    beat_d   = beat_q;
    ws_cnt_d = ws_cnt_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
        if (go && !abort) begin
          state_d  = ST_READ;
          rem_d    = len;
          beat_d   = '0;
          ws_cnt_d = '0;
        end
      end
      ST_READ: state_d = ST_DLY;
      ST_DLY: begin
        if (ws) begin
          if (ws_cnt_q == WSW'(MAX_WS)) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_READ;
            ws_cnt_d = ws_cnt_q + WSW'(1);
          end
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_READ;
          rem_d    = rem_q - CNT_W'(1);
          beat_d   = beat_q + CNT_W'(1);
          ws_cnt_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every busy-state transition and freezes the counters.
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      rem_d    = rem_q;
      beat_d   = beat_q;
      ws_cnt_d = ws_cnt_q;
    end

    rd_d   = (state_d == ST_READ) || (state_d == ST_DLY);
    ds_d   = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
    busy_d = (state_d != ST_IDLE);
  end

  // Beat, remaining-beat and wait-state counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      beat_q   <= '0;
      ws_cnt_q <= '0;
    end else begin
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      ws_cnt_q <= ws_cnt_d;
    end
  end

endmodule
